// File: rtl/fpu_defs.sv
// Shared FPU constants and types used by the FPU and the blocks that feed it.
// The flags type orders bits as {OF, UF, Zero, IX, IV, Inf}.
package fpu_defs;

    localparam int C_FPU01_OP    = 32;
    localparam int C_FPU01_RM    = 3;
    localparam int C_FPU01_CMD   = 4;
    localparam int C_FPU01_FLAGS = 6;

    localparam logic [C_FPU01_CMD-1:0] C_FPU01_ADD_CMD = 4'd0;
    localparam logic [C_FPU01_CMD-1:0] C_FPU01_SUB_CMD = 4'd1;
    localparam logic [C_FPU01_CMD-1:0] C_FPU01_MUL_CMD = 4'd2;
    localparam logic [C_FPU01_CMD-1:0] C_FPU01_DIV_CMD = 4'd3;

    typedef struct packed {
        logic OF;
        logic UF;
        logic Zero;
        logic IX;
        logic IV;
        logic Inf;
    } fpu_flags_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_comb.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping modulo N) wins; gnt is one-hot, id is its index.
module rr_arb_comb
    import fpu_defs::*;
#(
    parameter int N  = 4,
    parameter int IW = idWidth(N)
) (
    input  logic [N-1:0]  Req_SI,
    input  logic [IW-1:0] Prio_SI,
    output logic [N-1:0]  Gnt_SO,
    output logic [IW-1:0] GntId_SO,
    output logic          GntValid_SO
);

    int idxInt;
    logic [IW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        Gnt_SO      = '0;
        GntId_SO    = '0;
        GntValid_SO = 1'b0;
        idxInt      = 0;
        idx         = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idxInt = (int'(Prio_SI) + off) % N;
            idx    = IW'(idxInt);
            if (Req_SI[idx]) begin
                Gnt_SO      = '0;
                Gnt_SO[idx] = 1'b1;
                GntId_SO    = idx;
                GntValid_SO = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arb.sv
// Shares one pipelined FPU between NUM_REQ requesters: round-robin issue,
// an owner-tag pipeline matching the FPU latency, and head-of-line stall.
module fpu_share_arb
    import fpu_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FPU_LAT = 3
) (
    input  logic                                  Clk_CI,
    input  logic                                  Rst_RBI,
    input  logic [NUM_REQ-1:0]                    Req_SI,
    output logic [NUM_REQ-1:0]                    Gnt_SO,
    input  logic [NUM_REQ-1:0][C_FPU01_OP-1:0]    Operand_a_DI,
    input  logic [NUM_REQ-1:0][C_FPU01_OP-1:0]    Operand_b_DI,
    input  logic [NUM_REQ-1:0][C_FPU01_RM-1:0]    RM_SI,
    input  logic [NUM_REQ-1:0][C_FPU01_CMD-1:0]   OP_SI,
    output logic [NUM_REQ-1:0]                    RValid_SO,
    input  logic [NUM_REQ-1:0]                    RReady_SI,
    output logic [C_FPU01_OP-1:0]                 Result_DO,
    output fpu_flags_t                            Flags_DO,
    output logic [C_FPU01_OP-1:0]                 Fpu_Operand_a_DO,
    output logic [C_FPU01_OP-1:0]                 Fpu_Operand_b_DO,
    output logic [C_FPU01_RM-1:0]                 Fpu_RM_SO,
    output logic [C_FPU01_CMD-1:0]                Fpu_OP_SO,
    output logic                                  Fpu_Enable_SO,
    output logic                                  Fpu_Stall_SO,
    input  logic [C_FPU01_OP-1:0]                 Fpu_Result_DI,
    input  logic [C_FPU01_FLAGS-1:0]              Fpu_Flags_DI
);

    localparam int ID_W = idWidth(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]    prio_q, prio_d;
    logic [ID_W-1:0]    arbId;
    logic [NUM_REQ-1:0] arbGnt;
    logic               arbValid;
    logic               issue;
    logic               stall;
    logic               anyValid;
    tag_t [FPU_LAT-1:0] tags_q, tags_d;
    tag_t               head;

    rr_arb_comb #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .Req_SI      (Req_SI),
        .Prio_SI     (prio_q),
        .Gnt_SO      (arbGnt),
        .GntId_SO    (arbId),
        .GntValid_SO (arbValid)
    );

    assign head  = tags_q[FPU_LAT-1];
    assign stall = head.valid & ~RReady_SI[head.id];
    // Reset gates the grant so nothing is accepted while the pipeline is held clear.
    assign issue = Rst_RBI & arbValid & ~stall;

    assign Gnt_SO           = issue ? arbGnt : '0;
    assign Fpu_Operand_a_DO = Operand_a_DI[arbId];
    assign Fpu_Operand_b_DO = Operand_b_DI[arbId];
    assign Fpu_RM_SO        = RM_SI[arbId];
    assign Fpu_OP_SO        = OP_SI[arbId];
    assign Fpu_Stall_SO     = stall;
    assign Fpu_Enable_SO    = issue | anyValid;
    assign Result_DO        = Fpu_Result_DI;
    assign Flags_DO         = fpu_flags_t'(Fpu_Flags_DI);

    always_comb begin
        anyValid = 1'b0;
        for (int i = 0; i < FPU_LAT; i++) begin
            anyValid = anyValid | tags_q[i].valid;
        end
    end

    always_comb begin
        RValid_SO = '0;
        if (head.valid) begin
            RValid_SO[head.id] = 1'b1;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (issue) begin
            prio_d = (int'(arbId) == NUM_REQ - 1) ? '0 : arbId + ID_W'(1);
        end
    end

    // Tags advance in lockstep with the FPU stages and freeze with them.
    always_comb begin
        tags_d = tags_q;
        if (!stall) begin
            tags_d[0] = {issue, arbId};
            for (int i = 1; i < FPU_LAT; i++) begin
                tags_d[i] = tags_q[i-1];
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            prio_q <= '0;
            tags_q <= '0;
        end else begin
            prio_q <= prio_d;
            tags_q <= tags_d;
        end
    end

endmodule

// File: tb/tb_fpu_share_arb.sv
// Directed bench for fpu_share_arb with a 3-stage stand-in FPU that freezes on
// stall; operands are hand-chosen so each result identifies its owner.
module tb_fpu_share_arb;
    import fpu_defs::*;

    logic                          Clk_CI;
    logic                          Rst_RBI;
    logic [3:0]                    Req_SI;
    logic [3:0]                    Gnt_SO;
    logic [3:0][C_FPU01_OP-1:0]    opA, opB;
    logic [3:0][C_FPU01_RM-1:0]    rm;
    logic [3:0][C_FPU01_CMD-1:0]   cmd;
    logic [3:0]                    RValid_SO;
    logic [3:0]                    RReady_SI;
    logic [C_FPU01_OP-1:0]         Result_DO;
    fpu_flags_t                    Flags_DO;
    logic [C_FPU01_OP-1:0]         fpuA, fpuB;
    logic [C_FPU01_RM-1:0]         fpuRm;
    logic [C_FPU01_CMD-1:0]        fpuOp;
    logic                          fpuEnable, fpuStall;
    logic [C_FPU01_OP-1:0]         fpuResult;
    logic [C_FPU01_FLAGS-1:0]      fpuFlags;

    int checkCount = 0;
    int passCount  = 0;

    fpu_share_arb #(.NUM_REQ(4), .FPU_LAT(3)) dut (
        .Clk_CI           (Clk_CI),
        .Rst_RBI          (Rst_RBI),
        .Req_SI           (Req_SI),
        .Gnt_SO           (Gnt_SO),
        .Operand_a_DI     (opA),
        .Operand_b_DI     (opB),
        .RM_SI            (rm),
        .OP_SI            (cmd),
        .RValid_SO        (RValid_SO),
        .RReady_SI        (RReady_SI),
        .Result_DO        (Result_DO),
        .Flags_DO         (Flags_DO),
        .Fpu_Operand_a_DO (fpuA),
        .Fpu_Operand_b_DO (fpuB),
        .Fpu_RM_SO        (fpuRm),
        .Fpu_OP_SO        (fpuOp),
        .Fpu_Enable_SO    (fpuEnable),
        .Fpu_Stall_SO     (fpuStall),
        .Fpu_Result_DI    (fpuResult),
        .Fpu_Flags_DI     (fpuFlags)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    // Known vector 1.0 + 2.0 = 3.0; everything else is a tagging function.
    function automatic logic [31:0] fpuModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        if (op == C_FPU01_ADD_CMD && a == 32'h3F800000 && b == 32'h40000000)
            return 32'h40400000;
        return a ^ b ^ {28'd0, op};
    endfunction

    logic [31:0] s0A, s0B, s1A, s1B, s2A, s2B;
    logic [3:0]  s0Op, s1Op, s2Op;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s0A <= '0; s0B <= '0; s0Op <= '0;
            s1A <= '0; s1B <= '0; s1Op <= '0;
            s2A <= '0; s2B <= '0; s2Op <= '0;
        end else if (fpuEnable && !fpuStall) begin
            s0A <= fpuA; s0B <= fpuB; s0Op <= fpuOp;
            s1A <= s0A;  s1B <= s0B;  s1Op <= s0Op;
            s2A <= s1A;  s2B <= s1B;  s2Op <= s1Op;
        end
    end

    assign fpuResult = fpuModel(s2A, s2B, s2Op);
    assign fpuFlags  = {2'b00, s2Op};

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic idle(input int n);
        Req_SI = 4'b0000;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        Rst_RBI = 1'b0;
        Req_SI  = 4'b1111;
        tick();
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b0000) $display("[TB] FAIL reset_gnt got %b want 0000", Gnt_SO); else passCount++;
        checkCount++;
        if (RValid_SO !== 4'b0000) $display("[TB] FAIL reset_rvalid got %b want 0000", RValid_SO); else passCount++;
        checkCount++;
        if (fpuEnable !== 1'b0) $display("[TB] FAIL reset_enable got %b want 0", fpuEnable); else passCount++;
        checkCount++;
        if (fpuStall !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", fpuStall); else passCount++;
        tick();
        Rst_RBI = 1'b1;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b0001) $display("[TB] FAIL reset_first_gnt got %b want 0001", Gnt_SO); else passCount++;
        tick();
        idle(5);
    endtask

    // Pointer is 1 here (last grant went to 0).
    task automatic test_prio_wrap();
        Req_SI = 4'b1000;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b1000) $display("[TB] FAIL wrap_gnt3 got %b want 1000", Gnt_SO); else passCount++;
        tick();
        Req_SI = 4'b0011;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b0001) $display("[TB] FAIL wrap_ptr0 got %b want 0001", Gnt_SO); else passCount++;
        tick();
        Req_SI = 4'b1000;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b1000) $display("[TB] FAIL wrap_regrant3 got %b want 1000", Gnt_SO); else passCount++;
        tick();
        idle(5);
    endtask

    task automatic test_round_robin();
        logic [3:0]  expGnt, expRv;
        logic [31:0] expRes;
        for (int k = 0; k < 12; k++) begin
            Req_SI = (k < 8) ? 4'b1111 : 4'b0000;
            expGnt = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            expRv  = (k >= 3 && k < 11) ? (4'b0001 << ((k - 3) % 4)) : 4'b0000;
            @(negedge Clk_CI);
            checkCount++;
            if (Gnt_SO !== expGnt) $display("[TB] FAIL rr_gnt cycle %0d got %b want %b", k, Gnt_SO, expGnt); else passCount++;
            checkCount++;
            if (RValid_SO !== expRv) $display("[TB] FAIL rr_rvalid cycle %0d got %b want %b", k, RValid_SO, expRv); else passCount++;
            if (k < 8) begin
                checkCount++;
                if (fpuA !== opA[k % 4]) $display("[TB] FAIL rr_fpu_a cycle %0d got %h want %h", k, fpuA, opA[k % 4]); else passCount++;
            end
            if (k >= 3 && k < 11) begin
                expRes = fpuModel(opA[(k - 3) % 4], opB[(k - 3) % 4], cmd[(k - 3) % 4]);
                checkCount++;
                if (Result_DO !== expRes) $display("[TB] FAIL rr_result cycle %0d got %h want %h", k, Result_DO, expRes); else passCount++;
            end
            tick();
        end
        idle(3);
    endtask

    // Pointer is 0 here; leaves the pointer at 3.
    task automatic test_single_add();
        opA[2] = 32'h3F800000;
        opB[2] = 32'h40000000;
        cmd[2] = C_FPU01_ADD_CMD;
        Req_SI = 4'b0100;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b0100) $display("[TB] FAIL add_gnt got %b want 0100", Gnt_SO); else passCount++;
        tick();
        Req_SI = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk_CI);
            checkCount++;
            if (RValid_SO !== ((k == 3) ? 4'b0100 : 4'b0000))
                $display("[TB] FAIL add_rvalid cycle %0d got %b want %b", k, RValid_SO, (k == 3) ? 4'b0100 : 4'b0000);
            else passCount++;
            if (k == 3) begin
                checkCount++;
                if (Result_DO !== 32'h40400000) $display("[TB] FAIL add_result got %h want 40400000", Result_DO); else passCount++;
            end
            tick();
        end
        idle(2);
    endtask

    // Pointer is 3: Req 0010 grants 1, then pointer 2 grants 3.
    task automatic test_stall();
        logic [3:0] expRv [0:8];
        logic [3:0] expGnt[0:8];
        logic [3:0] reqs  [0:8];
        logic       expSt [0:8];
        logic [3:0] ready [0:8];
        reqs   = '{4'b0010, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        expGnt = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        expRv  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0000, 4'b0001};
        expSt  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ready  = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        for (int k = 0; k < 9; k++) begin
            Req_SI    = reqs[k];
            RReady_SI = ready[k];
            @(negedge Clk_CI);
            checkCount++;
            if (Gnt_SO !== expGnt[k]) $display("[TB] FAIL stall_gnt cycle %0d got %b want %b", k, Gnt_SO, expGnt[k]); else passCount++;
            checkCount++;
            if (RValid_SO !== expRv[k]) $display("[TB] FAIL stall_rvalid cycle %0d got %b want %b", k, RValid_SO, expRv[k]); else passCount++;
            checkCount++;
            if (fpuStall !== expSt[k]) $display("[TB] FAIL stall_flag cycle %0d got %b want %b", k, fpuStall, expSt[k]); else passCount++;
            if (k == 4) begin
                checkCount++;
                if (Result_DO !== fpuModel(opA[1], opB[1], cmd[1]))
                    $display("[TB] FAIL stall_held_result got %h want %h", Result_DO, fpuModel(opA[1], opB[1], cmd[1]));
                else passCount++;
            end
            if (k == 6) begin
                checkCount++;
                if (Result_DO !== fpuModel(opA[3], opB[3], cmd[3]))
                    $display("[TB] FAIL stall_next_result got %h want %h", Result_DO, fpuModel(opA[3], opB[3], cmd[3]));
                else passCount++;
            end
            tick();
        end
        RReady_SI = 4'b1111;
        idle(3);
    endtask

    // Pointer is 1: Req 0100 grants 2, then reset discards it.
    task automatic test_reset_mid();
        Req_SI = 4'b0100;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b0100) $display("[TB] FAIL midrst_gnt got %b want 0100", Gnt_SO); else passCount++;
        tick();
        Req_SI  = 4'b0000;
        Rst_RBI = 1'b0;
        tick();
        Rst_RBI = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk_CI);
            checkCount++;
            if (RValid_SO !== 4'b0000) $display("[TB] FAIL midrst_rvalid cycle %0d got %b want 0000", k, RValid_SO); else passCount++;
            tick();
        end
        Req_SI = 4'b1111;
        @(negedge Clk_CI);
        checkCount++;
        if (Gnt_SO !== 4'b0001) $display("[TB] FAIL midrst_ptr got %b want 0001", Gnt_SO); else passCount++;
        tick();
        idle(4);
    endtask

    initial begin
        Rst_RBI   = 1'b0;
        Req_SI    = 4'b0000;
        RReady_SI = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            opA[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
            opB[i] = 32'h0A00_0000 + 32'(i) * 32'h1000;
            rm[i]  = 3'(i);
            cmd[i] = C_FPU01_SUB_CMD + 4'(i);
        end
        test_reset();
        test_prio_wrap();
        test_round_robin();
        test_single_add();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fpu_share_arb.md
# fpu_share_arb

Round-robin arbiter and scheduler that shares one pipelined `fpu` instance between `NUM_REQ` requesters, such as cores in a cluster. It accepts operations through per-requester req/gnt handshakes and issues at most one per cycle into the FPU input register. It tracks the owner of every in-flight operation in a tag pipeline that matches the FPU latency. It returns each result to its owner with valid/ready, and stalls the whole FPU pipeline when the owner of the head result is not ready.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `FPU_LAT`, default 3: cycles from the issue clock edge to a valid result on `Fpu_Result_DI`; counts the FPU input register plus core stages; must be ≥ 1.

Ports (reset Rst_RBI, asynchronous, active-low; clock Clk_CI):
- `Clk_CI`  in  1  clock
- `Rst_RBI`  in  1  asynchronous active-low reset
- `Req_SI`  in  `NUM_REQ`  operation request per requester
- `Gnt_SO`  out  `NUM_REQ`  one-hot grant; the operation is accepted at the clock edge
- `Operand_a_DI`, `Operand_b_DI`  in  `NUM_REQ`×`C_FPU01_OP`  operands
- `RM_SI`  in  `NUM_REQ`×`C_FPU01_RM`  rounding mode
- `OP_SI`  in  `NUM_REQ`×`C_FPU01_CMD`  command
- `RValid_SO`  out  `NUM_REQ`  result valid for that requester, at most one bit set
- `RReady_SI`  in  `NUM_REQ`  requester accepts result
- `Result_DO`  out  `C_FPU01_OP`  result, broadcast to all requesters
- `Flags_DO`  out  `C_FPU01_FLAGS`  {OF, UF, Zero, IX, IV, Inf}, broadcast
- `Fpu_Operand_a_DO`, `Fpu_Operand_b_DO`, `Fpu_RM_SO`, `Fpu_OP_SO`  out  (FPU widths)  muxed operation to the FPU inputs
- `Fpu_Enable_SO`  out  1  FPU enable
- `Fpu_Stall_SO`  out  1  FPU stall (freezes input register and core)
- `Fpu_Result_DI`  in  `C_FPU01_OP`  FPU result
- `Fpu_Flags_DI`  in  `C_FPU01_FLAGS`  FPU flags

## Operation
- **Arbitration**
  - Combinational round-robin.
  - Priority pointer `Prio_SP` is `ID_W` = max(1, $clog2(`NUM_REQ`)) bits wide; reset value 0.
  - Search order: `Prio_SP`, `Prio_SP`+1, … modulo `NUM_REQ`.
  - On a grant to index i, `Prio_SP` ← (i+1) mod `NUM_REQ`.
- **Grant gating**
  - `Gnt_SO` = 0 while `Fpu_Stall_SO` = 1.
  - Otherwise the first requesting index in search order is granted in the same cycle `Req_SI` is seen.
- **FPU drive**
  - `Fpu_*_DO` carry the granted requester's operands.
  - When there is no grant they carry requester 0's operands; this value is don't-care.
- **Tag pipeline**
  - `FPU_LAT` stages of {valid, id}.
  - Stage 0 loads {issue, granted id}; each stage shifts when not stalled and holds when stalled.
  - Head = stage `FPU_LAT`-1.
- **Result routing**
  - `RValid_SO[head.id]` = head.valid; all other bits 0.
  - `Result_DO`/`Flags_DO` = `Fpu_Result_DI`/`Fpu_Flags_DI` unregistered.
- **Stall**
  - `Fpu_Stall_SO` = head.valid & ~`RReady_SI[head.id]`.
  - Drops results with no valid head: an invalid head never stalls.
- **Enable**
  - `Fpu_Enable_SO` = issue | OR of all tag valids.
- **Ordering and simultaneous events**
  - Results are strictly in issue order.
  - A requester can be granted in the same cycle it receives a result.
- **Reset mid-operation**
  - Tag pipeline is cleared and in-flight results are discarded.
  - No `RValid_SO` after reset until a new issue has travelled `FPU_LAT` cycles.
- **NUM_REQ = 1**
  - Pointer stays 0; the block degenerates to gnt = req & ~stall.

## Timing
- Reset values: `Gnt_SO`=0, `RValid_SO`=0, `Fpu_Stall_SO`=0, `Fpu_Enable_SO`=0, `Prio_SP`=0, all tag valids 0.
- Issue at edge t (Req & Gnt high before t) → `RValid_SO` high during cycle t+`FPU_LAT`−1 → … exactly `FPU_LAT` unstalled cycles after the issue edge.
- Throughput: one operation per cycle with no stalls.
- Each stalled cycle adds exactly one cycle of latency to every in-flight operation.
- Grant is combinational from `Req_SI`, `Prio_SP` and `RReady_SI` via stall.
  - Requesters must not make `Req_SI` depend on `Gnt_SO`.
  - Requesters must hold `Req_SI` and operands stable until granted.
- Handshake completes on the edge where `RValid_SO` & `RReady_SI` are both 1.

## Structure
- Add to `fpu_defs`: `C_FPU01_FLAGS` = 6 and typedef `fpu_flags_t` (packed {OF, UF, Zero, IX, IV, Inf}).
- `C_FPU01_OP`, `C_FPU01_RM` and `C_FPU01_CMD` are reused from `fpu_defs`.
- One sub-module: `rr_arb_comb` (parameter N; inputs req and pointer; outputs one-hot gnt and gnt index).
- Tag pipeline and stall logic live in the top module.
- Integration top: this block plus `fpu`, with `Fpu_*` connected port-for-port.

## Test plan
All scenarios use `NUM_REQ`=4, `FPU_LAT`=3, all `RReady_SI`=1 unless stated.
1. Reset: hold `Rst_RBI`=0 with `Req_SI`=4'b1111 → `Gnt_SO`=0, `RValid_SO`=0, `Fpu_Enable_SO`=0; release → first grant goes to index 0.
2. `Req_SI`=4'b1111 for 8 cycles → grants 0,1,2,3,0,1,2,3; `RValid_SO` repeats the same sequence starting 3 cycles after the first grant.
3. Only requester 2 issues a=0x3F800000, b=0x40000000 with an ADD command → `RValid_SO`=4'b0100 exactly 3 cycles after the grant edge, with `Result_DO`=0x40400000.
4. Stall:
   - Setup: back-to-back issues from 1 then 3; hold `RReady_SI[1]`=0 for 2 cycles when its result arrives.
   - During the hold: `Fpu_Stall_SO`=1, `Gnt_SO`=0, `RValid_SO`=4'b0010 held.
   - After release: requester 3's result follows 1 cycle after the handshake of requester 1's result.
5. Reset asserted 1 cycle after an issue → no `RValid_SO` ever appears for that operation.
6. `Req_SI`=4'b1000 with `Prio_SP`=1 → grant 3, and `Prio_SP` becomes 0.
